// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Imported by the read-port and top-level modules.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_RD = 2;

    // Widest pending vector popcount supports (ADDR_W up to 8).
    localparam int REGFILE_MAX_DEPTH = 256;

    function automatic int unsigned popcount(
        input logic [REGFILE_MAX_DEPTH-1:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < REGFILE_MAX_DEPTH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write bypass and next-state busy.
// Holds its outputs when rd_en is low.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              is_zero,
    input  logic [DATA_W-1:0] mem_word,
    input  logic              pend_bit,
    input  logic              wr_hit,
    input  logic              rsv_hit,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt;

    always_comb begin
        data_nxt = mem_word;
        busy_nxt = rsv_hit | (pend_bit & ~wr_hit);
        if (BYPASS && wr_hit) begin
            data_nxt = wr_data;
        end
        if (is_zero) begin
            data_nxt = '0;
            busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending scoreboard.
// Owns the storage array, the pending vector and its population count.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = wr_en  && !(ZERO_REG && wr_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

    // Reserve is applied last so a newer producer wins over writeback.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) begin
            pend_nxt[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            pend     <= pend_nxt;
            pend_cnt <= (ADDR_W+1)'(popcount(
                REGFILE_MAX_DEPTH'(pend_nxt)));
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .BYPASS (BYPASS)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en[g]),
            .is_zero  (ZERO_REG && addr == '0),
            .mem_word (mem[addr]),
            .pend_bit (pend[addr]),
            .wr_hit   (wr_en && wr_addr == addr),
            .rsv_hit  (rsv_en && rsv_addr == addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[g*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against a reference model.
// Default parameters: 32x32, two read ports, zero register and bypass on.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   rd_en = '0;
    logic [AW-1:0]   ra [NR];
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            rsv_en = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;
    logic [AW:0]     pend_cnt;

    logic [DW-1:0] mem_m [DEPTH];
    bit            pend_m [DEPTH];
    logic [DW-1:0] exp_d [NR];
    logic          exp_b [NR];

    int total = 0;
    int bad = 0;

    assign rd_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend_cnt (pend_cnt)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(pend_m[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            pend_m[i] = 1'b0;
        end
        for (int p = 0; p < NR; p++) begin
            exp_d[p] = '0;
            exp_b[p] = 1'b0;
        end
    endtask

    // One clock: predict from the rules, clock, update model, check.
    task automatic step(string tag);
        for (int p = 0; p < NR; p++) begin
            if (rd_en[p]) begin
                if (ra[p] == 0) begin
                    exp_d[p] = '0;
                    exp_b[p] = 1'b0;
                end else begin
                    exp_d[p] = (wr_en && wr_addr == ra[p]) ?
                               wr_data : mem_m[ra[p]];
                    if (rsv_en && rsv_addr == ra[p])
                        exp_b[p] = 1'b1;
                    else if (wr_en && wr_addr == ra[p])
                        exp_b[p] = 1'b0;
                    else
                        exp_b[p] = pend_m[ra[p]];
                end
            end
        end
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            mem_m[wr_addr] = wr_data;
            pend_m[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) pend_m[rsv_addr] = 1'b1;
        #1;
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s.data%0d", tag, p),
                64'(rd_data[p*DW +: DW]), 64'(exp_d[p]));
            chk($sformatf("%s.busy%0d", tag, p),
                64'(rd_busy[p]), 64'(exp_b[p]));
        end
        chk({tag, ".cnt"}, 64'(pend_cnt), 64'(model_cnt()));
        wr_en = 1'b0;
        rsv_en = 1'b0;
        rd_en = '0;
    endtask

    task automatic rd2(int a0, int a1);
        rd_en = 2'b11;
        ra[0] = AW'(a0);
        ra[1] = AW'(a1);
    endtask

    task automatic wr(int a, logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    task automatic rsv(int a);
        rsv_en = 1'b1;
        rsv_addr = AW'(a);
    endtask

    initial begin
        ra[0] = '0;
        ra[1] = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.data", 64'(rd_data), 64'd0);
        chk("rst.busy", 64'(rd_busy), 64'd0);
        chk("rst.cnt", 64'(pend_cnt), 64'd0);
        rst_n = 1'b1;

        rd2(0, 5);
        step("rd0_5");
        rd2(31, 31);
        step("rd31");

        wr(7, 32'hDEADBEEF);
        step("wr7");
        rd2(7, 7);
        step("rd7");

        wr(0, 32'h1234);
        step("wr0");
        rd2(0, 0);
        step("rd0");

        wr(3, 32'hA5A5A5A5);
        rd2(3, 7);
        step("byp3");

        rsv(9);
        rd2(9, 9);
        step("rsv9");
        wr(9, 32'h55);
        rd2(9, 3);
        step("wr9");

        wr(12, 32'hC0FFEE);
        rsv(12);
        step("wrrsv12");
        rd2(12, 0);
        step("rd12");

        for (int i = 0; i < DEPTH; i++) begin
            rsv(i);
            step("rsvall");
        end
        chk("cnt31", 64'(pend_cnt), 64'd31);
        rsv(5);
        step("rsvdup");
        chk("cntdup", 64'(pend_cnt), 64'd31);
        wr(31, 32'hFFFF0031);
        rd2(31, 30);
        step("wr31");

        for (int i = 0; i < DEPTH; i++) begin
            wr(i, $urandom);
            step("clr");
        end
        wr(4, 32'h44);
        step("wrnp");
        chk("cntnp", 64'(pend_cnt), 64'd0);

        for (int n = 0; n < 400; n++) begin
            rd_en = NR'($urandom);
            for (int p = 0; p < NR; p++)
                ra[p] = n[0] ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_en = 1'($urandom);
            wr_addr = n[0] ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_data = $urandom;
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = n[1] ? AW'($urandom_range(0, 3)) : AW'($urandom);
            step("rand");
        end

        for (int i = 1; i < 6; i++) begin
            rsv(i);
            wr(i + 10, 32'(i) * 32'h1111);
            rd2(i, i + 10);
            step("pre");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.data", 64'(rd_data), 64'd0);
        chk("arst.busy", 64'(rd_busy), 64'd0);
        chk("arst.cnt", 64'(pend_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        rd2(11, 3);
        step("post");
        rd2(12, 1);
        step("post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
